// File: rtl/cpu_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pipe_pkg
//   Shared types and constants for the CPU pipeline hazard controller.
//   - pipe_state_e : sequencer states RUN / MEM_WAIT / DRAIN / HALTED
//   - CPU_REG_W    : register-specifier width used by the pipeline
//   - STALL_* / FLUSH_* : bit positions inside the stall and flush vectors
//
//   Stall vector targets  : PC, IF_ID, ID_EX, EX_MEM   (STALL_IF..STALL_MEM)
//   Flush vector targets  : IF_ID, ID_EX, EX_MEM, MEM_WB (FLUSH_ID..FLUSH_WB)
//   Stall bit i (i >= 1) and flush bit i-1 act on the same stage register;
//   the top relies on that ordering when resolving stall/flush conflicts.
// -----------------------------------------------------------------------------
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } pipe_state_e;

    localparam int CPU_REG_W = 5;

    localparam int N_STALL   = 4;
    localparam int N_FLUSH   = 4;

    localparam int STALL_IF  = 0;
    localparam int STALL_ID  = 1;
    localparam int STALL_EX  = 2;
    localparam int STALL_MEM = 3;

    localparam int FLUSH_ID  = 0;
    localparam int FLUSH_EX  = 1;
    localparam int FLUSH_MEM = 2;
    localparam int FLUSH_WB  = 3;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundle between the pipeline stage registers and the hazard controller.
//   master : pipeline side (drives hazard inputs, receives stall/flush)
//   slave  : hazard controller side
//
//   pipeline -> controller:
//     id_use_s, id_use_t, id_s_reg, id_t_reg   ID-stage source usage
//     ex_re, ex_use_dst_reg, ex_dst_reg        EX-stage load / destination
//     mem_re, mem_we, mem_rdy                  MEM-stage access handshake
//     mem_br_taken, mem_hlt                    MEM-stage control events
//   controller -> pipeline:
//     stall_if, stall_id, stall_ex, stall_mem  hold PC / IF_ID / ID_EX / EX_MEM
//     flush_id, flush_ex, flush_mem, flush_wb  bubble IF_ID / ID_EX / EX_MEM / MEM_WB
//     mem_timeout                              1-cycle pulse, access abandoned
//     halted                                   pipe drained after HLT (sticky)
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if
    import cpu_pipe_pkg::*;
#(
    parameter int REG_W = CPU_REG_W
);

    logic             id_use_s;
    logic             id_use_t;
    logic [REG_W-1:0] id_s_reg;
    logic [REG_W-1:0] id_t_reg;
    logic             ex_re;
    logic             ex_use_dst_reg;
    logic [REG_W-1:0] ex_dst_reg;
    logic             mem_re;
    logic             mem_we;
    logic             mem_rdy;
    logic             mem_br_taken;
    logic             mem_hlt;

    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             stall_mem;
    logic             flush_id;
    logic             flush_ex;
    logic             flush_mem;
    logic             flush_wb;
    logic             mem_timeout;
    logic             halted;

    modport master (
        output id_use_s, id_use_t, id_s_reg, id_t_reg,
        output ex_re, ex_use_dst_reg, ex_dst_reg,
        output mem_re, mem_we, mem_rdy, mem_br_taken, mem_hlt,
        input  stall_if, stall_id, stall_ex, stall_mem,
        input  flush_id, flush_ex, flush_mem, flush_wb,
        input  mem_timeout, halted
    );

    modport slave (
        input  id_use_s, id_use_t, id_s_reg, id_t_reg,
        input  ex_re, ex_use_dst_reg, ex_dst_reg,
        input  mem_re, mem_we, mem_rdy, mem_br_taken, mem_hlt,
        output stall_if, stall_id, stall_ex, stall_mem,
        output flush_id, flush_ex, flush_mem, flush_wb,
        output mem_timeout, halted
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_haz_detect.sv
// -----------------------------------------------------------------------------
// haz_detect
//   Combinational load-use comparator. Flags when the instruction in EX is a
//   load writing a non-zero register that the instruction in ID reads.
//   Ports:
//     id_use_s / id_use_t   in  ID instruction reads s / t register
//     id_s_reg / id_t_reg   in  ID source specifiers
//     ex_re                 in  EX instruction is a load
//     ex_use_dst_reg        in  EX instruction writes a destination
//     ex_dst_reg            in  EX destination specifier
//     load_use              out hazard present this cycle
// -----------------------------------------------------------------------------
module haz_detect
    import cpu_pipe_pkg::*;
#(
    parameter int REG_W = CPU_REG_W
) (
    input  logic             id_use_s,
    input  logic             id_use_t,
    input  logic [REG_W-1:0] id_s_reg,
    input  logic [REG_W-1:0] id_t_reg,
    input  logic             ex_re,
    input  logic             ex_use_dst_reg,
    input  logic [REG_W-1:0] ex_dst_reg,
    output logic             load_use
);

    logic [1:0]       src_use;
    logic [REG_W-1:0] src_reg [2];
    logic [1:0]       src_hit;

    assign src_use    = {id_use_t, id_use_s};
    assign src_reg[0] = id_s_reg;
    assign src_reg[1] = id_t_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_reg[gi] == ex_dst_reg);
        end
    endgenerate

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign load_use = ex_re && ex_use_dst_reg && (ex_dst_reg != '0) && (|src_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Detects load-use
//   hazards, holds the pipe during multi-cycle memory accesses (with timeout),
//   squashes wrong-path instructions on taken branches and drains the pipe on
//   HLT. Stall/flush outputs are combinational from state and inputs so they
//   act in the same cycle; state and counters are registered.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     haz          pipeline_hazard_ctrl_if.slave (hazard inputs, stall/flush,
//                  mem_timeout, halted)
//   Optional (macro PIPE_HAZ_PERF_EN defined):
//     perf_stall_cnt[31:0]  cycles with any stall asserted
//     perf_flush_cnt[31:0]  branch-flush events
//     perf_to_cnt[15:0]     memory timeouts
//   Counters wrap modulo their width and reset to 0.
//
//   Parameters: REG_W, MEM_TO_MAX (MEM wait limit), DRAIN_CYC (HLT-in-MEM to
//   halted latency in cycles).
//   Priority each cycle: HLT > memory wait > branch > load-use.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int REG_W      = CPU_REG_W,
    parameter int MEM_TO_MAX = 64,
    parameter int DRAIN_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_hazard_ctrl_if.slave haz
`ifdef PIPE_HAZ_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt,
    output logic [15:0]          perf_to_cnt
`endif
);

    localparam int WAIT_W  = $clog2(MEM_TO_MAX + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

    pipe_state_e        state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [DRAIN_W-1:0] drain_nxt;

    logic [N_STALL-1:0] stall_raw;
    logic [N_STALL-1:0] stall_res;
    logic [N_FLUSH-1:0] flush_raw;
    logic               timeout;
    logic               br_flush;
    logic               load_use;
    logic               mem_req;
    logic               run_like;

    haz_detect #(
        .REG_W (REG_W)
    ) u_haz_detect (
        .id_use_s       (haz.id_use_s),
        .id_use_t       (haz.id_use_t),
        .id_s_reg       (haz.id_s_reg),
        .id_t_reg       (haz.id_t_reg),
        .ex_re          (haz.ex_re),
        .ex_use_dst_reg (haz.ex_use_dst_reg),
        .ex_dst_reg     (haz.ex_dst_reg),
        .load_use       (load_use)
    );

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        stall_raw   = '0;
        flush_raw   = '0;
        timeout     = 1'b0;
        br_flush    = 1'b0;
        mem_req     = haz.mem_re | haz.mem_we;
        drain_nxt   = drain_cnt_q + DRAIN_W'(1);

        // The cycle on which a pending access completes behaves like RUN:
        // a branch or HLT held off by the wait is acted on right here.
        run_like = (state_q == RUN) || ((state_q == MEM_WAIT) && haz.mem_rdy);

        case (state_q)
            MEM_WAIT: begin
                if (!haz.mem_rdy) begin
                    if (wait_cnt_q == WAIT_W'(MEM_TO_MAX)) begin
                        // Give up on the access: pulse timeout and let the pipe go.
                        timeout    = 1'b1;
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end else begin
                        stall_raw           = '1;
                        flush_raw[FLUSH_WB] = 1'b1;
                        // Never passes MEM_TO_MAX: the limit is caught above.
                        wait_cnt_d          = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            DRAIN: begin
                stall_raw[STALL_IF]  = 1'b1;
                flush_raw[FLUSH_ID]  = 1'b1;
                flush_raw[FLUSH_EX]  = 1'b1;
                flush_raw[FLUSH_MEM] = 1'b1;
                drain_cnt_d          = drain_nxt;
                // HLT cycle plus DRAIN_CYC-1 drain cycles, then halted shows.
                if (drain_nxt >= DRAIN_W'(DRAIN_CYC - 1)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                stall_raw[STALL_IF]  = 1'b1;
                flush_raw[FLUSH_ID]  = 1'b1;
                flush_raw[FLUSH_EX]  = 1'b1;
                flush_raw[FLUSH_MEM] = 1'b1;
            end
            default: ;
        endcase

        if (run_like) begin
            if (haz.mem_hlt) begin
                stall_raw[STALL_IF]  = 1'b1;
                flush_raw[FLUSH_ID]  = 1'b1;
                flush_raw[FLUSH_EX]  = 1'b1;
                flush_raw[FLUSH_MEM] = 1'b1;
                state_d              = DRAIN;
                drain_cnt_d          = '0;
            end else if ((state_q == RUN) && mem_req && !haz.mem_rdy) begin
                stall_raw           = '1;
                flush_raw[FLUSH_WB] = 1'b1;
                state_d             = MEM_WAIT;
                wait_cnt_d          = WAIT_W'(1);
            end else if (haz.mem_br_taken) begin
                // Wrong-path instructions in IF_ID, ID_EX, EX_MEM are squashed;
                // this also overrides any load-use stall for the cycle.
                flush_raw[FLUSH_ID]  = 1'b1;
                flush_raw[FLUSH_EX]  = 1'b1;
                flush_raw[FLUSH_MEM] = 1'b1;
                br_flush             = 1'b1;
            end else if (load_use) begin
                stall_raw[STALL_IF] = 1'b1;
                stall_raw[STALL_ID] = 1'b1;
                flush_raw[FLUSH_EX] = 1'b1;
            end
        end
    end

    // A register that is being flushed must not also be held: flush wins.
    // PC has no flush, so stall_if passes straight through.
    assign stall_res[STALL_IF] = stall_raw[STALL_IF];
    generate
        for (genvar gi = 1; gi < N_STALL; gi++) begin : g_resolve
            assign stall_res[gi] = stall_raw[gi] & ~flush_raw[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Outputs are forced low while reset is held, even if inputs would
    // otherwise raise a combinational stall or flush.
    assign haz.stall_if    = rst_n & stall_res[STALL_IF];
    assign haz.stall_id    = rst_n & stall_res[STALL_ID];
    assign haz.stall_ex    = rst_n & stall_res[STALL_EX];
    assign haz.stall_mem   = rst_n & stall_res[STALL_MEM];
    assign haz.flush_id    = rst_n & flush_raw[FLUSH_ID];
    assign haz.flush_ex    = rst_n & flush_raw[FLUSH_EX];
    assign haz.flush_mem   = rst_n & flush_raw[FLUSH_MEM];
    assign haz.flush_wb    = rst_n & flush_raw[FLUSH_WB];
    assign haz.mem_timeout = rst_n & timeout;
    assign haz.halted      = rst_n & (state_q == HALTED);

`ifdef PIPE_HAZ_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [15:0] perf_to_q,    perf_to_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, |stall_res};
        perf_flush_d = perf_flush_q + {31'd0, br_flush};
        perf_to_d    = perf_to_q    + {15'd0, timeout};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_to_q    <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_to_q    <= perf_to_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_to_cnt    = perf_to_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Scenario bench for pipeline_hazard_ctrl. Each cycle the expected output
//   vector is queued as stimulus is driven, then popped and compared once the
//   combinational outputs settle. Vector bit order:
//   {stall_if, stall_id, stall_ex, stall_mem,
//    flush_id, flush_ex, flush_mem, flush_wb, mem_timeout, halted}
//   Define PIPE_HAZ_PERF_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam logic [9:0] E_NONE = 10'b0000000000;
    localparam logic [9:0] E_LU   = 10'b1100010000;
    localparam logic [9:0] E_MW   = 10'b1111000100;
    localparam logic [9:0] E_BR   = 10'b0000111000;
    localparam logic [9:0] E_HLT  = 10'b1000111000;
    localparam logic [9:0] E_HALT = 10'b1000111001;
    localparam logic [9:0] E_TO   = 10'b0000000010;

    typedef struct {
        string      tag;
        logic [9:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    exp_t sb_q [$];

    pipeline_hazard_ctrl_if #(.REG_W(5)) bus ();

`ifdef PIPE_HAZ_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
    logic [15:0] perf_to_cnt;
`endif

    pipeline_hazard_ctrl #(
        .REG_W      (5),
        .MEM_TO_MAX (64),
        .DRAIN_CYC  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .haz   (bus)
`ifdef PIPE_HAZ_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_to_cnt    (perf_to_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] obs();
        return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                bus.flush_id, bus.flush_ex, bus.flush_mem, bus.flush_wb,
                bus.mem_timeout, bus.halted};
    endfunction

    task automatic push(input string tag, input logic [9:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb_q.push_back(e);
    endtask

    task automatic set_idle();
        bus.id_use_s       = 1'b0;
        bus.id_use_t       = 1'b0;
        bus.id_s_reg       = 5'd0;
        bus.id_t_reg       = 5'd0;
        bus.ex_re          = 1'b0;
        bus.ex_use_dst_reg = 1'b0;
        bus.ex_dst_reg     = 5'd0;
        bus.mem_re         = 1'b0;
        bus.mem_we         = 1'b0;
        bus.mem_rdy        = 1'b0;
        bus.mem_br_taken   = 1'b0;
        bus.mem_hlt        = 1'b0;
    endtask

    // Load in EX writing r5, ID reading r5 through s.
    task automatic set_load_use();
        bus.ex_re          = 1'b1;
        bus.ex_use_dst_reg = 1'b1;
        bus.ex_dst_reg     = 5'd5;
        bus.id_use_s       = 1'b1;
        bus.id_s_reg       = 5'd5;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        set_load_use();
        bus.mem_re       = 1'b1;
        bus.mem_br_taken = 1'b1;
        bus.mem_hlt      = 1'b1;
        for (int c = 0; c < 2; c++) begin
            push("reset_outputs", E_NONE);
            #1;
            e = sb_q.pop_front();
            n_vec++;
            if (obs() !== e.v) begin
                n_err++;
                $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.v);
            end
            @(negedge clk);
        end
`ifdef PIPE_HAZ_PERF_EN
        n_vec++;
        if ({perf_stall_cnt, perf_flush_cnt, perf_to_cnt} !== 80'd0) begin
            n_err++;
            $display("FAIL perf_reset: observed %0d/%0d/%0d expected 0/0/0",
                     perf_stall_cnt, perf_flush_cnt, perf_to_cnt);
        end
`endif
        set_idle();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mem_wait();
        exp_t       e;
        logic [5:0] re_t  = 6'b011111;   // bit c = cycle c
        logic [5:0] rdy_t = 6'b010001;
        logic [9:0] exp_t_v [6] = '{E_NONE, E_MW, E_MW, E_MW, E_NONE, E_NONE};
        for (int c = 0; c < 6; c++) begin
            bus.mem_re  = re_t[c];
            bus.mem_rdy = rdy_t[c];
            push($sformatf("mem_wait_c%0d", c), exp_t_v[c]);
            #1;
            e = sb_q.pop_front();
            n_vec++;
            if (obs() !== e.v) begin
                n_err++;
                $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.v);
            end
            @(negedge clk);
        end
`ifdef PIPE_HAZ_PERF_EN
        n_vec++;
        if (perf_stall_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL perf_stall_3: observed %0d expected 3", perf_stall_cnt);
        end
`endif
        set_idle();
    endtask

    task automatic test_load_use();
        exp_t e;
        // {use_s, use_t, ex_re, ex_use_dst, s_reg, t_reg, dst_reg}
        logic [18:0] tab [8] = '{
            {4'b1011, 5'd5, 5'd0,  5'd5},
            {4'b0111, 5'd0, 5'd7,  5'd7},
            {4'b1011, 5'd0, 5'd0,  5'd0},
            {4'b0011, 5'd5, 5'd5,  5'd5},
            {4'b1101, 5'd5, 5'd5,  5'd5},
            {4'b1010, 5'd5, 5'd0,  5'd5},
            {4'b1111, 5'd3, 5'd4,  5'd9},
            {4'b1111, 5'd3, 5'd31, 5'd31}
        };
        logic [9:0] want [8] = '{E_LU, E_LU, E_NONE, E_NONE, E_NONE, E_NONE, E_NONE, E_LU};
        for (int c = 0; c < 8; c++) begin
            logic [18:0] row;
            row = tab[c];
            bus.id_use_s       = row[18];
            bus.id_use_t       = row[17];
            bus.ex_re          = row[16];
            bus.ex_use_dst_reg = row[15];
            bus.id_s_reg       = row[14:10];
            bus.id_t_reg       = row[9:5];
            bus.ex_dst_reg     = row[4:0];
            push($sformatf("load_use_c%0d", c), want[c]);
            #1;
            e = sb_q.pop_front();
            n_vec++;
            if (obs() !== e.v) begin
                n_err++;
                $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.v);
            end
            @(negedge clk);
        end
        set_idle();
    endtask

    task automatic test_timeout();
        exp_t e;
        bus.mem_we  = 1'b1;
        bus.mem_rdy = 1'b0;
        for (int c = 0; c < 66; c++) begin
            if (c == 65) bus.mem_we = 1'b0;
            if (c < 64)       push($sformatf("timeout_wait_c%0d", c), E_MW);
            else if (c == 64) push("timeout_pulse", E_TO);
            else              push("timeout_after", E_NONE);
            #1;
            e = sb_q.pop_front();
            n_vec++;
            if (obs() !== e.v) begin
                n_err++;
                $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.v);
            end
            @(negedge clk);
        end
`ifdef PIPE_HAZ_PERF_EN
        n_vec++;
        if (perf_to_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL perf_to_1: observed %0d expected 1", perf_to_cnt);
        end
`endif
        set_idle();
    endtask

    task automatic test_branch();
        exp_t       e;
        logic [5:0] br_t  = 6'b011111;
        logic [5:0] lu_t  = 6'b000001;
        logic [5:0] re_t  = 6'b011100;
        logic [5:0] rdy_t = 6'b010000;
        logic [9:0] want [6] = '{E_BR, E_BR, E_MW, E_MW, E_BR, E_NONE};
        for (int c = 0; c < 6; c++) begin
            set_idle();
            if (lu_t[c]) set_load_use();
            bus.mem_br_taken = br_t[c];
            bus.mem_re       = re_t[c];
            bus.mem_rdy      = rdy_t[c];
            push($sformatf("branch_c%0d", c), want[c]);
            #1;
            e = sb_q.pop_front();
            n_vec++;
            if (obs() !== e.v) begin
                n_err++;
                $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.v);
            end
            @(negedge clk);
        end
`ifdef PIPE_HAZ_PERF_EN
        n_vec++;
        if (perf_flush_cnt !== 32'd3) begin
            n_err++;
            $display("FAIL perf_flush_3: observed %0d expected 3", perf_flush_cnt);
        end
`endif
        set_idle();
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                bus.mem_re  = 1'b1;
                bus.mem_rdy = 1'b0;
            end
            if (c == 2) rst_n = 1'b0;
            if (c == 3) begin
                rst_n       = 1'b1;
                bus.mem_re  = 1'b0;
                set_load_use();
            end
            if (c < 2)       push($sformatf("rst_wait_c%0d", c), E_MW);
            else if (c == 2) push("rst_mid_wait", E_NONE);
            else             push("rst_back_to_run", E_LU);
            #1;
            e = sb_q.pop_front();
            n_vec++;
            if (obs() !== e.v) begin
                n_err++;
                $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.v);
            end
`ifdef PIPE_HAZ_PERF_EN
            if (c == 2) begin
                n_vec++;
                if ({perf_stall_cnt, perf_flush_cnt, perf_to_cnt} !== 80'd0) begin
                    n_err++;
                    $display("FAIL perf_rst_mid: observed %0d/%0d/%0d expected 0/0/0",
                             perf_stall_cnt, perf_flush_cnt, perf_to_cnt);
                end
            end
`endif
            @(negedge clk);
        end
        set_idle();
    endtask

    task automatic test_halt();
        exp_t e;
        logic [9:0] want [8] = '{E_HLT, E_HLT, E_HALT, E_HALT, E_HALT, E_NONE, E_NONE, E_LU};
        for (int c = 0; c < 8; c++) begin
            set_idle();
            if (c == 0) bus.mem_hlt = 1'b1;
            if (c == 3 || c == 4) begin
                set_load_use();
                bus.mem_re       = 1'b1;
                bus.mem_br_taken = 1'b1;
            end
            if (c == 5) rst_n = 1'b0;
            if (c == 6) rst_n = 1'b1;
            if (c == 7) set_load_use();
            push($sformatf("halt_c%0d", c), want[c]);
            #1;
            e = sb_q.pop_front();
            n_vec++;
            if (obs() !== e.v) begin
                n_err++;
                $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.v);
            end
            @(negedge clk);
        end
        set_idle();
    endtask

    // Load-use, then an access that waits, then HLT arriving on the ready cycle.
    task automatic test_back_to_back();
        exp_t e;
        logic [9:0] want [7] = '{E_LU, E_MW, E_MW, E_HLT, E_HLT, E_HALT, E_NONE};
        for (int c = 0; c < 7; c++) begin
            set_idle();
            if (c == 0) set_load_use();
            if (c >= 1 && c <= 3) bus.mem_re = 1'b1;
            if (c == 3) begin
                bus.mem_rdy = 1'b1;
                bus.mem_hlt = 1'b1;
            end
            if (c == 6) rst_n = 1'b0;
            push($sformatf("b2b_c%0d", c), want[c]);
            #1;
            e = sb_q.pop_front();
            n_vec++;
            if (obs() !== e.v) begin
                n_err++;
                $display("FAIL %s: observed %b expected %b", e.tag, obs(), e.v);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        set_idle();
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        test_reset();
        test_mem_wait();
        test_load_use();
        test_timeout();
        test_branch();
        test_reset_mid_wait();
        test_halt();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
